rv32i_ram_arbiter: RTL
======================

// Module: rv32i_ram_arbiter
// PURPOSE
//   Shares the single-port data/firmware RAM between the instruction-fetch requester (I) and the
//   ALU load/store requester (D). Each access runs as a multi-cycle transaction with a req/ack
//   handshake. Sits between the core's fetch/ALU memory ports and the RAM macro.
//   Replaces direct ALU->RAM wiring so that fetch and data share one port without collisions.
// PARAMETERS
//   DATA_WIDTH   32  RAM word width
//   RAM_WIDTH    31  RAM address width
//   RAM_LATENCY  1   cycles from address issue to valid ram_rdata; legal 1..4
// PORTS
//   clk          in   1           system clock, rising edge
//   rst_n        in   1           asynchronous active-low reset
//   if_req       in   1           fetch request; held with if_addr until if_ack
//   if_addr      in   RAM_WIDTH   fetch address
//   if_ack       out  1           1-cycle pulse: fetch done, if_rdata valid that cycle
//   if_rdata     out  DATA_WIDTH  fetched word
//   d_req        in   1           data request; held with d_we/d_addr/d_wdata until d_ack
//   d_we         in   1           1 = store, 0 = load
//   d_addr       in   RAM_WIDTH   data address
//   d_wdata      in   DATA_WIDTH  store data
//   d_ack        out  1           1-cycle pulse: data access done; d_rdata valid if load
//   d_rdata      out  DATA_WIDTH  load data
//   ram_address  out  RAM_WIDTH   RAM address
//   ram_we       out  1           RAM write enable
//   ram_wdata    out  DATA_WIDTH  RAM write data
//   ram_rdata    in   DATA_WIDTH  RAM read data, valid RAM_LATENCY cycles after issue
//   busy         out  1           high in any state other than IDLE
// BEHAVIOUR
//   - All outputs registered. Reset: every output 0, FSM=IDLE, wait counter=0, RR pointer=I.
//   - FSM states:
//       IDLE  -> ISSUE  when any req=1; latch grantee, we, addr, wdata.
//       ISSUE -> WAIT   ram_address/ram_we/ram_wdata driven from latched values. ram_we is
//                       high only in ISSUE and only for a D store.
//       WAIT  -> RESP   after RAM_LATENCY cycles (counter 0..RAM_LATENCY-1); ram_address held.
//       RESP  -> IDLE   grantee ack=1 for exactly one cycle. rdata captured from ram_rdata
//                       (D store: d_rdata keeps its old value).
//   - Latency req->ack = RAM_LATENCY+2 cycles. One access per RAM_LATENCY+3 cycles at most.
//   - Requester drops req in the cycle after ack. A req still high in IDLE is a new request.
//   - req is sampled only in IDLE. Changing req or payload mid-transaction has no effect.
//   - ram_address, ram_wdata are 0 in IDLE. if_rdata/d_rdata hold their last value until the next ack.
//   - Arbitration in IDLE: D has fixed priority over I (load/store retires before next fetch).
//   - Both req=1 in IDLE: D is granted; I is granted in the next IDLE if still requesting.
//   - Addresses pass through unmodified. No alignment or range check.
//     Wrap at 2^RAM_WIDTH is the RAM's concern.
//   - rst_n low mid-transaction: abort immediately, no ack issued, ram_we forced 0 asynchronously.
//   - Never both acks in the same cycle. Never ram_we=1 outside ISSUE.
// CONFIGURATION
//   MEM_ARB_RR_EN defined: round-robin arbitration.
//     - When both requesters are pending, the one not granted last wins.
//     - A 1-bit pointer updates on each grant. Single requests are granted unconditionally.
//   MEM_ARB_RR_EN undefined: fixed D>I priority as above; pointer logic is not built.
// TESTING
//   1 Reset: rst_n=0 with reqs toggling -> all outputs 0, busy=0; rst_n=1 -> FSM IDLE.
//   2 Single fetch, RAM_LATENCY=1: if_req=1, if_addr=0x10, RAM returns 0x00500093
//     -> if_ack at cycle 3, if_rdata=0x00500093, ram_we never 1.
//   3 Store then load: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> ram_we=1 one cycle,
//     d_ack at +3. Then load from 0x40 -> d_rdata=0xDEADBEEF.
//   4 Simultaneous: if_req=d_req=1 in the same cycle -> d_ack first, if_ack RAM_LATENCY+3
//     cycles later. With MEM_ARB_RR_EN and last grant=D -> if_ack first.
//   5 Abort: pull rst_n low during WAIT of a store -> ram_we=0 at once, no d_ack.
//     After release, a fresh d_req completes normally.
//   6 RAM_LATENCY=4: back-to-back fetches held high -> ack every 7 cycles, busy drops for one cycle between.

Source files
------------

// File: rtl/rv32i_ram_arbiter.sv
// rv32i_ram_arbiter: shares one single-port RAM between instruction fetch (I) and load/store (D)
//
// Each access runs as IDLE -> ISSUE -> WAIT (RAM_LATENCY cycles) -> RESP -> IDLE.
// Every output comes straight from a register. req->ack latency is RAM_LATENCY+2 cycles.
// A new access can start at most once every RAM_LATENCY+3 cycles.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration between I and D.
// If it is left undefined, D always wins over I.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req/if_addr                 fetch request; held by the requester until if_ack
//   if_ack/if_rdata                one-cycle done pulse and the fetched word
//   d_req/d_we/d_addr/d_wdata      load/store request; held by the requester until d_ack
//   d_ack/d_rdata                  one-cycle done pulse and the load data
//   ram_address/ram_we/ram_wdata   RAM command; ram_rdata returns RAM_LATENCY cycles after issue
//   busy                           high whenever the FSM is outside IDLE
module rv32i_ram_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_WIDTH   = 31,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [RAM_WIDTH-1:0]  if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [RAM_WIDTH-1:0]  d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [RAM_WIDTH-1:0]  ram_address,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam int CW = RAM_LATENCY > 1 ? $clog2(RAM_LATENCY) : 1;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          gnt_d;
  logic          we_q;
  logic          pick_d;
`ifdef MEM_ARB_RR_EN
  // last_d records which requester won the previous grant. On a tie, the other requester wins.
  logic last_d;
  assign pick_d = (if_req && d_req) ? !last_d : d_req;
`else
  assign pick_d = d_req;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt_d       <= 1'b0;
      we_q        <= 1'b0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      ram_address <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      busy        <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (if_req || d_req) begin
          state       <= ISSUE;
          busy        <= 1'b1;
          gnt_d       <= pick_d;
          we_q        <= pick_d && d_we;
          ram_address <= pick_d ? d_addr : if_addr;
          ram_we      <= pick_d && d_we;
          ram_wdata   <= (pick_d && d_we) ? d_wdata : '0;
`ifdef MEM_ARB_RR_EN
          last_d      <= pick_d;
`endif
        end
        ISSUE: begin
          state  <= WAIT;
          ram_we <= 1'b0;
          cnt    <= '0;
        end
        WAIT: if (cnt == CW'(RAM_LATENCY - 1)) begin
          // Data captured on this edge reaches the requester together with its ack.
          state  <= RESP;
          if_ack <= !gnt_d;
          d_ack  <= gnt_d;
          if (!gnt_d) if_rdata <= ram_rdata;
          if (gnt_d && !we_q) d_rdata <= ram_rdata;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          if_ack      <= 1'b0;
          d_ack       <= 1'b0;
          ram_address <= '0;
          ram_wdata   <= '0;
        end
      endcase
    end
  end
  a_one_ack: assert property (@(posedge clk) disable iff (!rst_n) !(if_ack && d_ack));
  a_we_issue: assert property (@(posedge clk) disable iff (!rst_n) ram_we |-> state == ISSUE);
endmodule
